// File: rtl/serial_code_lock_n.sv
// Serial N-digit code lock: user code entry, in-place reprogramming, failure lockout cleared by an admin code.
// Optional macro DIGIT_TIMEOUT_EN adds an idle timeout that abandons a partial entry after TIMEOUT_CYCLES.
module serial_code_lock_n #(
    parameter int DIGIT_W = 4,
    parameter int CODE_LEN = 4,
    parameter int MAX_FAIL = 3,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h0000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] ADMIN_CODE = 16'h0129,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          digitValid,
    input  logic                          clear,
    input  logic                          setMode,
    output logic                          unlockLight,
    output logic                          errorLight,
    output logic                          warningLight,
    output logic                          setDone,
    output logic [$clog2(MAX_FAIL+1)-1:0] failCount,
    output logic [$clog2(CODE_LEN)-1:0]   entryIndex,
    output logic [2:0]                    stateDbg
);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int IDX_W  = $clog2(CODE_LEN);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {S_ENTRY, S_OPEN, S_SET, S_ERROR, S_LOCK} stateT;

    stateT             state;
    logic [CODE_W-1:0] storedCode;
    logic [CODE_W-1:0] shadowCode;
    logic              mismatch;

    function automatic logic [DIGIT_W-1:0] digitAt(input logic [CODE_W-1:0] code,
                                                   input logic [IDX_W-1:0] idx);
        return code[(CODE_LEN-1-int'(idx))*DIGIT_W +: DIGIT_W];
    endfunction

    logic             lastDigit;
    logic [IDX_W-1:0] indexInc;
    logic             userMiss;
    logic             adminMatch;
    logic             lockNow;
    logic             timeoutHit;
    logic             clearEff;

    assign lastDigit  = (entryIndex == IDX_W'(CODE_LEN-1));
    assign indexInc   = entryIndex + IDX_W'(1);
    assign userMiss   = mismatch | (digit != digitAt(storedCode, entryIndex));
    assign adminMatch = (digit == digitAt(ADMIN_CODE, entryIndex));
    assign lockNow    = (int'(failCount) + 1 >= MAX_FAIL);
    assign clearEff   = clear | timeoutHit;
    assign stateDbg   = state;

`ifdef DIGIT_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idleCnt;
    logic              idleActive;

    assign idleActive = (entryIndex != '0) &&
                        (state == S_ENTRY || state == S_SET || state == S_LOCK);
    assign timeoutHit = idleActive && !digitValid && (idleCnt == IDLE_W'(TIMEOUT_CYCLES-1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            idleCnt <= '0;
        else if (!idleActive || digitValid || clear || timeoutHit)
            idleCnt <= '0;
        else
            idleCnt <= idleCnt + IDLE_W'(1);
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Lights are written alongside each state change so they track the new state with no extra cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_ENTRY;
            storedCode   <= DEFAULT_CODE;
            shadowCode   <= '0;
            entryIndex   <= '0;
            mismatch     <= 1'b0;
            failCount    <= '0;
            unlockLight  <= 1'b0;
            errorLight   <= 1'b0;
            warningLight <= 1'b0;
            setDone      <= 1'b0;
        end else begin
            setDone <= 1'b0;
            case (state)
                S_ENTRY: begin
                    if (clearEff) begin
                        entryIndex <= '0;
                        mismatch   <= 1'b0;
                    end else if (digitValid) begin
                        if (lastDigit) begin
                            entryIndex <= '0;
                            mismatch   <= 1'b0;
                            if (!userMiss) begin
                                state       <= S_OPEN;
                                unlockLight <= 1'b1;
                                failCount   <= '0;
                            end else if (!lockNow) begin
                                state      <= S_ERROR;
                                errorLight <= 1'b1;
                                failCount  <= failCount + FAIL_W'(1);
                            end else begin
                                state        <= S_LOCK;
                                warningLight <= 1'b1;
                                failCount    <= FAIL_W'(MAX_FAIL);
                            end
                        end else begin
                            entryIndex <= indexInc;
                            mismatch   <= userMiss;
                        end
                    end
                end
                S_OPEN: begin
                    if (clearEff) begin
                        state       <= S_ENTRY;
                        unlockLight <= 1'b0;
                        entryIndex  <= '0;
                    end else if (setMode) begin
                        state      <= S_SET;
                        entryIndex <= '0;
                    end
                end
                S_SET: begin
                    if (clearEff || !setMode) begin
                        state      <= S_OPEN;
                        entryIndex <= '0;
                    end else if (digitValid) begin
                        shadowCode[(CODE_LEN-1-int'(entryIndex))*DIGIT_W +: DIGIT_W] <= digit;
                        if (lastDigit) begin
                            // Last digit lands in the low bits, so commit it directly with the shadow.
                            storedCode  <= {shadowCode[CODE_W-1:DIGIT_W], digit};
                            setDone     <= 1'b1;
                            state       <= S_ENTRY;
                            unlockLight <= 1'b0;
                            entryIndex  <= '0;
                        end else begin
                            entryIndex <= indexInc;
                        end
                    end
                end
                S_ERROR: begin
                    if (clearEff) begin
                        state      <= S_ENTRY;
                        errorLight <= 1'b0;
                    end
                end
                S_LOCK: begin
                    if (clearEff) begin
                        entryIndex <= '0;
                    end else if (digitValid) begin
                        if (!adminMatch) begin
                            entryIndex <= '0;
                        end else if (lastDigit) begin
                            state        <= S_ENTRY;
                            warningLight <= 1'b0;
                            failCount    <= '0;
                            entryIndex   <= '0;
                        end else begin
                            entryIndex <= indexInc;
                        end
                    end
                end
                default: begin
                    state        <= S_ENTRY;
                    unlockLight  <= 1'b0;
                    errorLight   <= 1'b0;
                    warningLight <= 1'b0;
                    entryIndex   <= '0;
                    mismatch     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_code_lock_n.sv
// Bench for serial_code_lock_n: code table plus hand sequences for lockout, set abort, clear priority and async reset.
// The idle-timeout sequence runs only when DIGIT_TIMEOUT_EN is defined.
module tb_serial_code_lock_n;
    localparam int OUT_W = 12;
    localparam int TO = 8;
    localparam logic [2:0] ST_ENTRY = 3'd0, ST_OPEN = 3'd1, ST_SET = 3'd2,
                           ST_ERROR = 3'd3, ST_LOCK = 3'd4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digitValid = 1'b0;
    logic       clear = 1'b0;
    logic       setMode = 1'b0;
    logic       unlockLight, errorLight, warningLight, setDone;
    logic [1:0] failCount, entryIndex;
    logic [2:0] stateDbg;

    serial_code_lock_n #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .digit(digit), .digitValid(digitValid),
        .clear(clear), .setMode(setMode), .unlockLight(unlockLight),
        .errorLight(errorLight), .warningLight(warningLight), .setDone(setDone),
        .failCount(failCount), .entryIndex(entryIndex), .stateDbg(stateDbg)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: {unlock, error, warning, setDone, failCount, entryIndex, state}
    logic [OUT_W-1:0] exp_q[$];
    int nChecks = 0;
    int nFails = 0;
    logic [OUT_W-1:0] actOut;
    assign actOut = {unlockLight, errorLight, warningLight, setDone, failCount, entryIndex, stateDbg};

    function automatic logic [OUT_W-1:0] mk(input logic u, input logic e, input logic w,
                                            input logic sd, input logic [1:0] fc,
                                            input logic [1:0] ix, input logic [2:0] st);
        return {u, e, w, sd, fc, ix, st};
    endfunction

    task automatic checkOut(input string name);
        logic [OUT_W-1:0] e;
        nChecks++;
        if (exp_q.size() == 0) begin
            nFails++;
            $display("FAIL %s: no expected entry queued, got %h", name, actOut);
        end else begin
            e = exp_q.pop_front();
            if (actOut !== e) begin
                nFails++;
                $display("FAIL %s: got %h expected %h", name, actOut, e);
            end
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        @(negedge CLK);
        digit = d;
        digitValid = 1'b1;
        @(negedge CLK);
        digitValid = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] c, input int n);
        for (int i = 0; i < n; i++) strobe(c[15-4*i -: 4]);
    endtask

    task automatic pulseClear();
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
    endtask

    typedef struct {
        logic             preClear;
        logic             doSet;
        logic [15:0]      code;
        logic [OUT_W-1:0] expOut;
    } vecT;

    vecT vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r0, r1;
        vecs[0] = '{1'b0, 1'b0, 16'h0000, mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN)};
        vecs[1] = '{1'b0, 1'b1, 16'h5371, mk(0, 0, 0, 1, 2'd0, 2'd0, ST_ENTRY)};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, mk(0, 1, 0, 0, 2'd1, 2'd0, ST_ERROR)};
        vecs[3] = '{1'b1, 1'b0, 16'h5371, mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN)};
        vecs[4] = '{1'b1, 1'b0, 16'h1111, mk(0, 1, 0, 0, 2'd1, 2'd0, ST_ERROR)};
        vecs[5] = '{1'b1, 1'b0, 16'h1111, mk(0, 1, 0, 0, 2'd2, 2'd0, ST_ERROR)};
        vecs[6] = '{1'b1, 1'b0, 16'h1111, mk(0, 0, 1, 0, 2'd3, 2'd0, ST_LOCK)};

        repeat (2) @(negedge CLK);
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, ST_ENTRY));
        checkOut("reset");
        RST = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].preClear) pulseClear();
            if (vecs[v].doSet) begin
                @(negedge CLK);
                setMode = 1'b1;
            end
            exp_q.push_back(vecs[v].expOut);
            enterCode(vecs[v].code, 4);
            checkOut($sformatf("vec%0d", v));
            setMode = 1'b0;
        end

        // Lockout: wrong admin digit restarts, then the full admin code releases.
        exp_q.push_back(mk(0, 0, 1, 0, 2'd3, 2'd0, ST_LOCK));
        enterCode(16'h0150, 3);
        checkOut("lock_restart");
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, ST_ENTRY));
        enterCode(16'h0129, 4);
        checkOut("lock_release");
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN));
        enterCode(16'h5371, 4);
        checkOut("open_after_release");

        // Partial set abandoned by dropping setMode.
        @(negedge CLK);
        setMode = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd2, ST_SET));
        strobe(4'd9);
        strobe(4'd9);
        checkOut("set_partial");
        setMode = 1'b0;
        @(negedge CLK);
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN));
        checkOut("set_abort");
        pulseClear();
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN));
        enterCode(16'h5371, 4);
        checkOut("code_kept");

        // Clear together with a digit: clear wins, digit dropped.
        pulseClear();
        strobe(4'd5);
        @(negedge CLK);
        clear = 1'b1;
        digitValid = 1'b1;
        digit = 4'd3;
        @(negedge CLK);
        clear = 1'b0;
        digitValid = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, ST_ENTRY));
        checkOut("clear_wins");
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN));
        enterCode(16'h5371, 4);
        checkOut("after_clear_wins");

        // Random partial entry, then async reset in the middle of a cycle.
        pulseClear();
        r0 = 4'($urandom_range(0, 15));
        r1 = 4'($urandom_range(0, 15));
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd2, ST_ENTRY));
        strobe(r0);
        strobe(r1);
        checkOut("partial_idx");
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, ST_ENTRY));
        checkOut("async_reset");
        @(negedge CLK);
        RST = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd0, ST_OPEN));
        enterCode(16'h0000, 4);
        checkOut("default_after_reset");

`ifdef DIGIT_TIMEOUT_EN
        pulseClear();
        exp_q.push_back(mk(0, 1, 0, 0, 2'd1, 2'd0, ST_ERROR));
        enterCode(16'h1111, 4);
        checkOut("pre_timeout_fail");
        pulseClear();
        strobe(4'd3);
        repeat (TO) @(posedge CLK);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, ST_ENTRY));
        checkOut("timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/serial_code_lock_n.md
Name: serial_code_lock_n

Overview:
- Parametrised successor to the fixed 4-digit serial lock: N-digit code of W-bit digits, entered one digit per strobe.
- Stored user code in internal registers. Changing it is allowed only while unlocked, and the new code commits atomically.
- Counts failed attempts. After MAX_FAIL failures it enters lockout, which only the admin code clears.
- Sits between the keypad debouncer/strobe generator and the light/indicator drivers.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 4, digits per code; must be >= 2.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout; must be >= 1.
- DEFAULT_CODE, 16'h0000, user code loaded at reset; width CODE_LEN*DIGIT_W.
- ADMIN_CODE, 16'h0129, lockout release code; width CODE_LEN*DIGIT_W.
- TIMEOUT_CYCLES, 1000000, idle cycles before a partial entry is discarded; used only with the optional feature.
- Code packing: digit i (entry order, i=0 first) occupies bits [(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W].

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  asynchronous, active-low reset.
- digit  in  DIGIT_W  digit value; sampled only when digitValid=1.
- digitValid  in  1  one-cycle strobe, one digit per pulse.
- clear  in  1  one-cycle strobe; abandons the current entry or closes the lock.
- setMode  in  1  level; request to program a new code (honoured only in S_OPEN).
- unlockLight  out  1  high in S_OPEN and S_SET.
- errorLight  out  1  high in S_ERROR.
- warningLight  out  1  high in S_LOCK.
- setDone  out  1  one-cycle pulse when a new code commits.
- failCount  out  $clog2(MAX_FAIL+1)  consecutive failure count.
- entryIndex  out  $clog2(CODE_LEN)  next digit position for the active sequence.

Behaviour:
- Reset (RST=0, async) sets:
  - state S_ENTRY;
  - stored code DEFAULT_CODE;
  - index 0, mismatch flag 0, failCount 0;
  - all lights 0, setDone 0.
- Reset mid-operation discards any partial entry or partial set. Registers are driven only from the async reset and posedge CLK.
- All outputs are registered. A light changes in the cycle after the final digitValid is sampled (1-cycle latency).
- Simultaneous clear and digitValid: clear wins and the digit is dropped.
- S_ENTRY:
  - Each digitValid compares digit against stored digit[index] and ORs any mismatch into the flag; index then increments.
  - On the digit at index CODE_LEN-1:
    - full match -> S_OPEN, failCount=0;
    - mismatch with failCount+1 < MAX_FAIL -> S_ERROR, failCount+1;
    - mismatch with failCount+1 == MAX_FAIL -> S_LOCK, failCount=MAX_FAIL.
  - index and flag return to 0 at sequence end.
  - clear sets index=0 and flag=0. It does not count as a failure.
- S_OPEN:
  - digitValid is ignored.
  - clear -> S_ENTRY.
  - setMode=1 -> S_SET with index=0.
- S_SET:
  - Each digitValid writes the digit into a shadow register at index, then index increments.
  - After digit CODE_LEN-1: shadow copies into the stored code in the same clock edge, setDone pulses 1 cycle, state -> S_ENTRY.
  - setMode dropping or clear before completion -> S_OPEN. The stored code is unchanged.
- S_ERROR:
  - digitValid is ignored.
  - clear -> S_ENTRY (failCount retained).
- S_LOCK:
  - Digits are compared against ADMIN_CODE[index]. On any mismatch the digit is discarded and index=0 (immediate restart).
  - Full match -> S_ENTRY, failCount=0.
  - clear sets index=0 and the state stays S_LOCK.
  - setMode is ignored.
- Index wrap: index never exceeds CODE_LEN-1. It returns to 0 at the end of every sequence.

Optional Feature:
- Macro: DIGIT_TIMEOUT_EN.
- Defined:
  - An idle counter is added. It counts CLK cycles since the last accepted digitValid while index != 0 in S_ENTRY, S_SET or S_LOCK.
  - Reaching TIMEOUT_CYCLES acts exactly like clear in that state, and the counter resets to 0.
  - In S_ENTRY the timeout is not a failure.
- Undefined: no counter exists. A partial entry persists until clear or RST.

Test Plan:
- After reset, digits 0,0,0,0 -> unlockLight=1 one cycle after the 4th strobe; failCount=0.
- From S_OPEN: setMode=1, digits 5,3,7,1 -> setDone pulse and state S_ENTRY. Then 0,0,0,0 -> errorLight=1, failCount=1. Then clear, 5,3,7,1 -> unlockLight=1, failCount=0.
- Three wrong codes (1,1,1,1), each followed by clear -> after the 3rd: warningLight=1, failCount=3.
- In S_LOCK, entering 0,1,5 (mismatch at the 3rd digit) then 0,1,2,9 -> after the first 0,1,2,9 completes: warningLight=0, failCount=0, state S_ENTRY.
- In S_SET after 2 digits, drop setMode -> unlockLight=1 and the stored code is unchanged. Async RST asserted mid-entry -> all lights 0, entryIndex=0.
- With DIGIT_TIMEOUT_EN and TIMEOUT_CYCLES=8: one digit entered, then 8 idle cycles -> entryIndex=0 and failCount unchanged.
